// File: rtl/operand_entry.sv
// Keypad operand entry: keeps a 5-digit signed BCD entry for the display and
// converts it to a 32-bit two's-complement operand one digit per cycle.
module operand_entry #(
  parameter logic [3:0] MINUS_CODE = 4'hA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  output logic [23:0] BCD_I,
  output logic [2:0]  digit_count,
  output logic [31:0] operand,
  output logic        operand_valid
);

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [19:0] mag_r, mag_s;
  logic        neg_r, neg_s;
  logic [2:0]  count_r, count_s;
  logic [16:0] acc_r, acc_s;
  logic [2:0]  idx_r, idx_s;
  logic [31:0] operand_r, operand_s;
  logic        valid_r, valid_s;
  logic        ready_r;
  logic [23:0] bcd_r;
  logic        start_s;
  logic [3:0]  cur_digit_s;
  logic [31:0] acc_ext_s;

  function automatic logic [3:0] bcd_digit(input logic [19:0] m, input logic [2:0] i);
    case (i)
      3'd0:    bcd_digit = m[3:0];
      3'd1:    bcd_digit = m[7:4];
      3'd2:    bcd_digit = m[11:8];
      3'd3:    bcd_digit = m[15:12];
      3'd4:    bcd_digit = m[19:16];
      default: bcd_digit = 4'h0;
    endcase
  endfunction

  // Next-state logic: key decode in IDLE, one BCD digit folded in per CONV cycle.
  always_comb begin
    state_s     = state_r;
    mag_s       = mag_r;
    neg_s       = neg_r;
    count_s     = count_r;
    acc_s       = acc_r;
    idx_s       = idx_r;
    operand_s   = operand_r;
    valid_s     = valid_r;
    start_s     = 1'b0;
    cur_digit_s = bcd_digit(mag_r, idx_r);
    acc_ext_s   = 32'd0;
    case (state_r)
      IDLE: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if ((count_r != 3'd5) && !((count_r == 3'd0) && (key_code == 4'd0))) begin
              mag_s   = {mag_r[15:0], key_code};
              count_s = count_r + 3'd1;
              start_s = 1'b1;
            end else begin
              start_s = 1'b0;
            end
          end else begin
            case (key_code)
              4'd10: begin
                if (count_r != 3'd0) begin
                  mag_s   = {4'h0, mag_r[19:4]};
                  count_s = count_r - 3'd1;
                  start_s = 1'b1;
                  // Zero is never shown or converted as negative.
                  if (mag_s == 20'd0) begin
                    neg_s = 1'b0;
                  end else begin
                    neg_s = neg_r;
                  end
                end else begin
                  start_s = 1'b0;
                end
              end
              4'd11: begin
                if (mag_r != 20'd0) begin
                  neg_s   = ~neg_r;
                  start_s = 1'b1;
                end else begin
                  start_s = 1'b0;
                end
              end
              4'd12: begin
                mag_s     = 20'd0;
                neg_s     = 1'b0;
                count_s   = 3'd0;
                operand_s = 32'd0;
                valid_s   = 1'b1;
              end
              default: start_s = 1'b0;
            endcase
          end
        end else begin
          start_s = 1'b0;
        end
        if (start_s) begin
          state_s = CONV;
          acc_s   = 17'd0;
          idx_s   = 3'd4;
          valid_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      CONV: begin
        acc_s = {acc_r[13:0], 3'b000} + {acc_r[15:0], 1'b0} + {13'd0, cur_digit_s};
        idx_s = idx_r - 3'd1;
        if (idx_r == 3'd0) begin
          acc_ext_s = {15'd0, acc_s};
          operand_s = neg_r ? (32'd0 - acc_ext_s) : acc_ext_s;
          valid_s   = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = CONV;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and output registers; reset also aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      mag_r     <= 20'd0;
      neg_r     <= 1'b0;
      count_r   <= 3'd0;
      acc_r     <= 17'd0;
      idx_r     <= 3'd0;
      operand_r <= 32'd0;
      valid_r   <= 1'b1;
      ready_r   <= 1'b1;
      bcd_r     <= 24'd0;
    end else begin
      state_r   <= state_s;
      mag_r     <= mag_s;
      neg_r     <= neg_s;
      count_r   <= count_s;
      acc_r     <= acc_s;
      idx_r     <= idx_s;
      operand_r <= operand_s;
      valid_r   <= valid_s;
      ready_r   <= (state_s == IDLE);
      bcd_r     <= {(neg_s ? MINUS_CODE : 4'h0), mag_s};
    end
  end

  assign key_ready     = ready_r;
  assign BCD_I         = bcd_r;
  assign digit_count   = count_r;
  assign operand       = operand_r;
  assign operand_valid = valid_r;

endmodule
